// File: rtl/rv_pkg.sv
// Shared RV32 constants for the integer register file slice.
// Widths and the hard-wired zero register index.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-result scoreboard for long-latency MDU write-backs.
// Tracks one bit per register; drives issue-ready and decode stall.
module regfile_scoreboard
    import rv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_en,
    input  logic          wb_mdu,
    input  logic [AW-1:0] wb_rd,
    input  logic          issue,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          issue_ready,
    output logic          stall
);

    logic [NREG-1:0] pending;
    logic            clr;
    logic            set;
    logic            clr_hit1;
    logic            clr_hit2;
    logic            stall1;
    logic            stall2;

    assign clr = wb_en & wb_mdu & (wb_rd != REG_ZERO);

    // A retiring MDU result frees its slot for a new issue in the same cycle.
    assign issue_ready = (issue_rd == REG_ZERO)
                       | ~pending[issue_rd]
                       | (clr & (wb_rd == issue_rd));

    assign set = issue & (issue_rd != REG_ZERO) & issue_ready;

    assign clr_hit1 = clr & (wb_rd == rs1);
    assign clr_hit2 = clr & (wb_rd == rs2);

    assign stall1 = (rs1 != REG_ZERO) & pending[rs1] & ~clr_hit1;
    assign stall2 = (rs2 != REG_ZERO) & pending[rs2] & ~clr_hit2;
    assign stall  = stall1 | stall2;

    // Set is applied after clear so a same-index collision stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (clr) begin
                pending[wb_rd] <= 1'b0;
            end
            if (set) begin
                pending[issue_rd] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_sink.sv
// Architectural integer register file fed by the write-back stage.
// Two combinational read ports with write-through bypass.
module regfile_wb_sink
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Ctl_RegWrite_in,
    input  logic [AW-1:0]   Rd_in,
    input  logic [XLEN-1:0] WriteDatatoReg_in,
    input  logic            Mdu_Wb_in,
    input  logic [AW-1:0]   Rs1_in,
    input  logic [AW-1:0]   Rs2_in,
    output logic [XLEN-1:0] ReadData1_out,
    output logic [XLEN-1:0] ReadData2_out,
    input  logic            Mdu_Issue_in,
    input  logic [AW-1:0]   Mdu_Rd_in,
    output logic            Mdu_IssueReady_out,
    output logic            Stall_out
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_en;

    assign wr_en = Ctl_RegWrite_in & (Rd_in != REG_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[Rd_in] <= WriteDatatoReg_in;
        end
    end

    always_comb begin
        ReadData1_out = regs[Rs1_in];
        if (Rs1_in == REG_ZERO) begin
            ReadData1_out = '0;
        end else if (wr_en && (Rs1_in == Rd_in)) begin
            ReadData1_out = WriteDatatoReg_in;
        end
    end

    always_comb begin
        ReadData2_out = regs[Rs2_in];
        if (Rs2_in == REG_ZERO) begin
            ReadData2_out = '0;
        end else if (wr_en && (Rs2_in == Rd_in)) begin
            ReadData2_out = WriteDatatoReg_in;
        end
    end

    regfile_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_en       (Ctl_RegWrite_in),
        .wb_mdu      (Mdu_Wb_in),
        .wb_rd       (Rd_in),
        .issue       (Mdu_Issue_in),
        .issue_rd    (Mdu_Rd_in),
        .rs1         (Rs1_in),
        .rs2         (Rs2_in),
        .issue_ready (Mdu_IssueReady_out),
        .stall       (Stall_out)
    );

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed bench for regfile_wb_sink: stimulus queues expectations,
// a negedge monitor pops them and compares against the outputs.
module tb_regfile_wb_sink;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        mwb;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        iss;
    logic [4:0]  mrd;
    logic        rdy;
    logic        stl;

    typedef struct {
        string       name;
        bit          c1;
        logic [31:0] e1;
        bit          c2;
        logic [31:0] e2;
        bit          cs;
        logic        es;
        bit          cr;
        logic        er;
    } exp_t;

    exp_t q[$];
    int   n_cmp;
    int   n_err;

    regfile_wb_sink dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .Ctl_RegWrite_in    (we),
        .Rd_in              (rd),
        .WriteDatatoReg_in  (wd),
        .Mdu_Wb_in          (mwb),
        .Rs1_in             (rs1),
        .Rs2_in             (rs2),
        .ReadData1_out      (d1),
        .ReadData2_out      (d2),
        .Mdu_Issue_in       (iss),
        .Mdu_Rd_in          (mrd),
        .Mdu_IssueReady_out (rdy),
        .Stall_out          (stl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic w, input logic [4:0] r,
                       input logic [31:0] d, input logic m,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic i, input logic [4:0] mr);
        we  = w;
        rd  = r;
        wd  = d;
        mwb = m;
        rs1 = a;
        rs2 = b;
        iss = i;
        mrd = mr;
    endtask

    task automatic expect_v(input string nm,
                            input bit c1, input logic [31:0] e1,
                            input bit c2, input logic [31:0] e2,
                            input bit cs, input logic es,
                            input bit cr, input logic er);
        exp_t e;
        e.name = nm;
        e.c1 = c1; e.e1 = e1;
        e.c2 = c2; e.e2 = e2;
        e.cs = cs; e.es = es;
        e.cr = cr; e.er = er;
        q.push_back(e);
    endtask

    // Monitor: compare every queued expectation away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.c1) begin
                    n_cmp++;
                    if (d1 !== e.e1) begin
                        n_err++;
                        $display("FAIL %s rd1 got %h want %h", e.name, d1, e.e1);
                    end
                end
                if (e.c2) begin
                    n_cmp++;
                    if (d2 !== e.e2) begin
                        n_err++;
                        $display("FAIL %s rd2 got %h want %h", e.name, d2, e.e2);
                    end
                end
                if (e.cs) begin
                    n_cmp++;
                    if (stl !== e.es) begin
                        n_err++;
                        $display("FAIL %s stall got %b want %b", e.name, stl, e.es);
                    end
                end
                if (e.cr) begin
                    n_cmp++;
                    if (rdy !== e.er) begin
                        n_err++;
                        $display("FAIL %s ready got %b want %b", e.name, rdy, e.er);
                    end
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 5, 31, 0, 5);
        expect_v("reset", 1, 0, 1, 0, 1, 0, 1, 1);

        step(); rst_n = 1'b1;
        expect_v("post_reset", 1, 0, 1, 0, 1, 0, 1, 1);

        step(); drv(1, 7, 32'hDEADBEEF, 0, 7, 0, 0, 0);
        expect_v("bypass_wr", 1, 32'hDEADBEEF, 1, 0, 1, 0, 1, 1);

        step(); drv(0, 0, 0, 0, 7, 7, 0, 0);
        expect_v("x7_hold", 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0, 0, 0);

        step(); drv(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
        expect_v("x0_wr_nobypass", 1, 0, 1, 0, 0, 0, 0, 0);

        step(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        expect_v("x0_read", 1, 0, 1, 0, 0, 0, 0, 0);

        step(); drv(0, 0, 0, 0, 9, 0, 1, 9);
        expect_v("issue9", 1, 0, 0, 0, 1, 0, 1, 1);

        for (int k = 0; k < 3; k++) begin
            step(); drv(0, 0, 0, 0, 9, 0, 0, 9);
            expect_v("stall9", 1, 0, 0, 0, 1, 1, 1, 0);
        end

        step(); drv(1, 9, 32'h42, 1, 9, 0, 0, 9);
        expect_v("wb9_bypass", 1, 32'h42, 0, 0, 1, 0, 1, 1);

        step(); drv(0, 0, 0, 0, 9, 0, 0, 9);
        expect_v("wb9_done", 1, 32'h42, 0, 0, 1, 0, 1, 1);

        step(); drv(0, 0, 0, 0, 0, 0, 1, 9);
        expect_v("reissue9", 0, 0, 0, 0, 1, 0, 1, 1);

        step(); drv(0, 0, 0, 0, 0, 9, 1, 9);
        expect_v("issue9_blocked", 0, 0, 1, 32'h42, 1, 1, 1, 0);

        step(); drv(0, 0, 0, 0, 0, 9, 0, 9);
        expect_v("still_pending", 0, 0, 0, 0, 1, 1, 1, 0);

        step(); drv(1, 9, 32'h99, 1, 9, 0, 1, 9);
        expect_v("clr_set_same", 1, 32'h99, 0, 0, 1, 0, 1, 1);

        step(); drv(0, 0, 0, 0, 9, 0, 0, 9);
        expect_v("set_wins", 1, 32'h99, 0, 0, 1, 1, 1, 0);

        step(); drv(1, 9, 32'h55, 0, 9, 0, 0, 9);
        expect_v("nonmdu_wb", 1, 32'h55, 0, 0, 1, 1, 1, 0);

        step(); drv(0, 0, 0, 0, 9, 0, 0, 9);
        expect_v("nonmdu_keep", 1, 32'h55, 0, 0, 1, 1, 1, 0);

        step(); drv(0, 0, 0, 0, 0, 0, 1, 0);
        expect_v("issue_x0", 0, 0, 0, 0, 1, 0, 1, 1);

        step(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        expect_v("x0_never_pending", 1, 0, 0, 0, 1, 0, 1, 1);

        step(); drv(1, 3, 32'hA5A5, 0, 0, 0, 1, 3);
        expect_v("issue3", 0, 0, 0, 0, 1, 0, 1, 1);

        step(); drv(0, 0, 0, 0, 3, 0, 0, 3);
        expect_v("x3_pending", 1, 32'hA5A5, 0, 0, 1, 1, 1, 0);

        step(); rst_n = 1'b0;
        expect_v("async_reset", 1, 0, 0, 0, 1, 0, 1, 1);

        step(); rst_n = 1'b1; drv(0, 0, 0, 0, 3, 9, 0, 9);
        expect_v("after_reset", 1, 0, 1, 0, 1, 0, 1, 1);

        @(negedge clk);
        @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain left %0d want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
